instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read port. Owns the PC and drives the byte address into the registered-read instruction memory. That memory returns a big-endian 32-bit word one clock after it samples the address.
- Pairs each returned word with its PC and presents it to decode over a valid/ready handshake.
- Supports stall and branch/jump redirect.
- Handles memory latency with one in-flight tag and a one-entry skid buffer.

Parameters:
- RESET_PC, 32'd0: PC loaded on reset.
- MEM_BYTES, 128: instruction memory size in bytes. Must be a power of two, at least 8. PC wraps modulo MEM_BYTES.
- INSTR_W, 32: instruction width.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-high reset.
- stall  in  1: suppresses new issue only.
- redirect_valid  in  1: load a new PC this cycle.
- redirect_pc  in  32: target PC.
- imem_addr  out  32: byte address to memory (PC register, direct).
- imem_en  out  1: a request is issued this cycle.
- imem_data  in  32: memory word for the address sampled at the previous edge.
- out_valid  out  1: instruction available.
- out_ready  in  1: decode accepts.
- out_instr  out  32: instruction word.
- out_pc  out  32: PC of out_instr.
- redirect_misaligned  out  1: registered flag; last redirect had redirect_pc[1:0] != 0.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On rst: pc_q=RESET_PC, infl_v=0, infl_pc=0, skid_v=0, skid_instr=0, skid_pc=0, redirect_misaligned=0.
  - Therefore in the reset cycle: out_valid=0, imem_en=0, imem_addr=RESET_PC, out_instr=0, out_pc=0.
- Registers:
  - pc_q: next PC to issue.
  - infl_v / infl_pc: a request issued at the last edge; its data is on imem_data this cycle.
  - skid_v / skid_instr / skid_pc: one buffered word.
- Issue:
  - issue = !rst && !redirect_valid && !stall && (!skid_v || out_ready) && (!infl_v || out_ready).
  - imem_en = issue.
  - On issue: infl_v<=1, infl_pc<=pc_q, pc_q<=(pc_q+4) mod MEM_BYTES. Otherwise infl_v<=0.
- Output mux:
  - If skid_v: out_* come from the skid.
  - Else if infl_v: out_instr=imem_data, out_pc=infl_pc.
  - out_valid=(skid_v||infl_v) && !redirect_valid.
  - Transfer occurs when out_valid && out_ready.
- Skid:
  - Loads when infl_v && !out_ready && !redirect_valid: skid<=(imem_data, infl_pc).
  - Clears when skid_v && out_ready.
  - Invariant: skid_v and infl_v are never both 1. The bench asserts this.
- Redirect (highest priority after rst):
  - pc_q<={redirect_pc[31:2],2'b00} mod MEM_BYTES.
  - infl_v<=0, skid_v<=0; the in-flight word is discarded.
  - redirect_misaligned<=|redirect_pc[1:0].
  - Issue resumes the next cycle from the new PC.
- Stall:
  - In-flight data is still delivered or skidded. PC holds.
  - When stall and redirect coincide, redirect wins.
- Latency: the first out_valid is in the 2nd cycle after rst deasserts. Steady state is 1 instruction per cycle with out_ready=1 and stall=0.
- Wrap: PC MEM_BYTES-4 is followed by PC 0, with no bubble.
- Backpressure: out_ready low for N cycles yields exactly one skidded word, no loss and no duplication. When out_ready rises, the skid drains and a new issue happens in the same cycle (no bubble).
- rst mid-operation overrides everything. All in-flight and skid contents are dropped.

Decomposition:
- Package fetch_pkg:
  - INSTR_W and ADDR_W=32.
  - PC_STEP=4.
  - NOP_INSTR=32'd0.
  - A localparam function computing the PC wrap mask from MEM_BYTES.
- Sub-module fetch_skid_buffer: one-entry (instr, pc) holding register with load/clear/flush. Holds skid_v/skid_instr/skid_pc.
- The top level holds the PC, the in-flight tag, issue logic and the output mux.

Test Plan:
- Reset then free run:
  - Memory model: words at 0,4,8,12 = 0; word at 16 = 32'h80220007; out_ready=1.
  - Required: out_pc sequence 0,4,8,12,16,20. At out_pc=16, out_instr=32'h80220007. First out_valid in the 2nd cycle after rst falls.
- Backpressure:
  - Free run, then drop out_ready for 3 cycles while out_pc=8 is presented.
  - Required: out_valid stays 1 with out_pc=8 held. imem_en=0 after the skid loads. On release, out_pc goes 8,12,16 on consecutive cycles, no gaps and no repeats.
- Redirect with in-flight:
  - Assert redirect_valid with redirect_pc=16 while out_pc=4 is pending.
  - Required: out_valid=0 that cycle; the word for PC 8 never appears; next delivered out_pc=16, instr 32'h80220007.
- Misaligned redirect:
  - redirect_pc=32'd18.
  - Required: fetch resumes at 16; redirect_misaligned=1 until the next redirect with an aligned target.
- Wrap and stall:
  - MEM_BYTES=128, redirect to 120.
  - Required: out_pc 120,124,0.
  - Then stall=1 for 2 cycles: the one in-flight word is delivered, then out_valid=0; fetch resumes at the held PC with no skip.
- Reset mid-backpressure:
  - Assert rst while skid_v=1.
  - Required: next cycle out_valid=0, imem_addr=RESET_PC; the first delivered out_pc after release is RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, constants and helpers for the instruction fetch unit.
// The PC wrap mask assumes the instruction memory size is a power of two.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32'd32;
    localparam int unsigned ADDR_W  = 32'd32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'd0;

    // Valid only for power-of-two memory sizes; ANDing with it gives PC mod size.
    function automatic logic [ADDR_W-1:0] pc_wrap_mask(input int unsigned mem_bytes);
        logic [ADDR_W-1:0] mask_v;
        mask_v = ADDR_W'(mem_bytes - 32'd1);
        return mask_v;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the instruction-memory read port and the decode-side handshake.
// master = fetch unit, slave = memory plus decode.
interface instruction_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned INSTR_W = fetch_pkg::INSTR_W,
    parameter int unsigned ADDR_W  = fetch_pkg::ADDR_W
);

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry (instr, pc) holding register that catches the in-flight word
// when decode is not ready; flush drops it without touching the payload.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               skid_v,
    output logic [INSTR_W-1:0] skid_instr,
    output logic [ADDR_W-1:0]  skid_pc
);

    // Holding register: reset, flush, load and drain with that priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_v     <= 1'b0;
            skid_instr <= {INSTR_W{1'b0}};
            skid_pc    <= {ADDR_W{1'b0}};
        end else if (flush) begin
            skid_v     <= 1'b0;
            skid_instr <= skid_instr;
            skid_pc    <= skid_pc;
        end else if (load) begin
            skid_v     <= 1'b1;
            skid_instr <= load_instr;
            skid_pc    <= load_pc;
        end else if (clear) begin
            skid_v     <= 1'b0;
            skid_instr <= skid_instr;
            skid_pc    <= skid_pc;
        end else begin
            skid_v     <= skid_v;
            skid_instr <= skid_instr;
            skid_pc    <= skid_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues reads to a registered-read memory,
// pairs returned words with their PC and hands them to decode with one skid slot.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_BYTES = 32'd128,
    parameter int unsigned INSTR_W   = fetch_pkg::INSTR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    instruction_fetch_unit_if.master  bus,
    output logic                      redirect_misaligned
);

    localparam logic [ADDR_W-1:0] PC_MASK = pc_wrap_mask(MEM_BYTES);

    logic [ADDR_W-1:0]  pc_r;
    logic               infl_v_r;
    logic [ADDR_W-1:0]  infl_pc_r;
    logic               redirect_misaligned_r;

    logic               issue_s;
    logic [ADDR_W-1:0]  pc_next_s;
    logic [ADDR_W-1:0]  redirect_target_s;
    logic               skid_load_s;
    logic               skid_clear_s;
    logic               skid_v_s;
    logic [INSTR_W-1:0] skid_instr_s;
    logic [ADDR_W-1:0]  skid_pc_s;
    logic               out_valid_s;
    logic [INSTR_W-1:0] out_instr_s;
    logic [ADDR_W-1:0]  out_pc_s;

    // Issue only when both the skid and the in-flight slot can make room this cycle.
    always_comb begin
        issue_s           = 1'b0;
        pc_next_s         = (pc_r + PC_STEP) & PC_MASK;
        redirect_target_s = {redirect_pc[31:2], 2'b00} & PC_MASK;
        if (rst || redirect_valid || stall) begin
            issue_s = 1'b0;
        end else if ((!skid_v_s || bus.out_ready) && (!infl_v_r || bus.out_ready)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // PC, in-flight tag and misalignment flag; redirect discards the in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r                  <= RESET_PC;
            infl_v_r              <= 1'b0;
            infl_pc_r             <= {ADDR_W{1'b0}};
            redirect_misaligned_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r                  <= redirect_target_s;
            infl_v_r              <= 1'b0;
            infl_pc_r             <= infl_pc_r;
            redirect_misaligned_r <= |redirect_pc[1:0];
        end else if (issue_s) begin
            pc_r                  <= pc_next_s;
            infl_v_r              <= 1'b1;
            infl_pc_r             <= pc_r;
            redirect_misaligned_r <= redirect_misaligned_r;
        end else begin
            pc_r                  <= pc_r;
            infl_v_r              <= 1'b0;
            infl_pc_r             <= infl_pc_r;
            redirect_misaligned_r <= redirect_misaligned_r;
        end
    end

    // Skid catches the word arriving while decode is busy.
    always_comb begin
        skid_load_s  = infl_v_r && !bus.out_ready && !redirect_valid;
        skid_clear_s = skid_v_s && bus.out_ready;
    end

    fetch_skid_buffer #(
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (skid_load_s),
        .clear      (skid_clear_s),
        .load_instr (bus.imem_data),
        .load_pc    (infl_pc_r),
        .skid_v     (skid_v_s),
        .skid_instr (skid_instr_s),
        .skid_pc    (skid_pc_s)
    );

    // Output mux: the skid is always older than anything in flight.
    always_comb begin
        out_instr_s = INSTR_W'(NOP_INSTR);
        out_pc_s    = {ADDR_W{1'b0}};
        if (skid_v_s) begin
            out_instr_s = skid_instr_s;
            out_pc_s    = skid_pc_s;
        end else if (infl_v_r) begin
            out_instr_s = bus.imem_data;
            out_pc_s    = infl_pc_r;
        end else begin
            out_instr_s = INSTR_W'(NOP_INSTR);
            out_pc_s    = {ADDR_W{1'b0}};
        end
        out_valid_s = (skid_v_s || infl_v_r) && !redirect_valid;
    end

    assign bus.imem_addr       = pc_r;
    assign bus.imem_en         = issue_s;
    assign bus.out_valid       = out_valid_s;
    assign bus.out_instr       = out_instr_s;
    assign bus.out_pc          = out_pc_s;
    assign redirect_misaligned = redirect_misaligned_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// checked by a scoreboard holding the expected in-order (pc, instr) stream.
module tb_instruction_fetch_unit;

    localparam int unsigned MB = 128;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst_i    = 1'b1;
    logic        stall_i  = 1'b0;
    logic        rv_i     = 1'b0;
    logic [31:0] rpc_i    = 32'd0;
    logic        mis_o;

    logic [7:0]  mem [MB];
    exp_t        q [$];
    logic [31:0] gen_pc   = 32'd0;
    logic        mis_m    = 1'b0;
    logic        prev_rst = 1'b1;
    logic        prev_rv  = 1'b0;
    logic [31:0] prev_rpc = 32'd0;
    logic        mon_en   = 1'b0;
    int          total    = 0;
    int          bad      = 0;
    int          xfers    = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC  (32'd0),
        .MEM_BYTES (MB),
        .INSTR_W   (32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst_i),
        .stall               (stall_i),
        .redirect_valid      (rv_i),
        .redirect_pc         (rpc_i),
        .bus                 (bus),
        .redirect_misaligned (mis_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int b;
        b = int'(a & 32'(MB - 1)) & ~3;
        return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
    endfunction

    // Registered-read big-endian memory
    always @(posedge clk) bus.imem_data <= mem_word(bus.imem_addr);

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: delivered words are consecutive PCs (mod MB) from the last reset/redirect target.
    task automatic drive(input logic r, input logic st, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
        exp_t e;
        if (prev_rst) mis_m = 1'b0;
        else if (prev_rv) mis_m = (prev_rpc[1:0] != 2'b00);
        prev_rst = r; prev_rv = rv; prev_rpc = rpc;
        rst_i = r; stall_i = st; rv_i = rv; rpc_i = rpc; bus.out_ready = rdy;
        if (r) begin
            q.delete(); gen_pc = 32'd0;
        end else if (rv) begin
            q.delete(); gen_pc = (rpc & ~32'd3) % MB;
        end
        while (q.size() < 8) begin
            e.pc = gen_pc; e.instr = mem_word(gen_pc);
            q.push_back(e);
            gen_pc = (gen_pc + 32'd4) % MB;
        end
    endtask

    task automatic go(input logic r, input logic st, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
        @(posedge clk); #1;
        drive(r, st, rv, rpc, rdy);
        @(negedge clk);
    endtask

    // Monitor: pop the scoreboard on every transfer and check per-cycle rules.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst_i) begin
            chk1("misaligned_flag", mis_o, mis_m);
            chk1("skid_infl_exclusive", dut.skid_v_s & dut.infl_v_r, 1'b0);
            if (rv_i) chk1("valid_on_redirect", bus.out_valid, 1'b0);
            if (stall_i || rv_i) chk1("en_blocked", bus.imem_en, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                xfers++;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: got pc %h expected no transfer", bus.out_pc);
                end else begin
                    e = q.pop_front();
                    chk("sb_pc", bus.out_pc, e.pc);
                    chk("sb_instr", bus.out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        int x0;
        logic r, st, rv, rdy;
        logic [31:0] rpc;
        for (int i = 0; i < int'(MB); i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[16] = 8'h80; mem[17] = 8'h22; mem[18] = 8'h00; mem[19] = 8'h07;
        bus.out_ready = 1'b1;

        // Reset state
        go(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("rst_valid", bus.out_valid, 1'b0);
        chk1("rst_en", bus.imem_en, 1'b0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk1("rst_mis", mis_o, 1'b0);
        mon_en = 1'b1;

        // Free run and latency
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("lat1_valid", bus.out_valid, 1'b0);
        chk1("lat1_en", bus.imem_en, 1'b1);
        chk("lat1_addr", bus.imem_addr, 32'd0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("lat2_valid", bus.out_valid, 1'b1);
        chk("lat2_pc", bus.out_pc, 32'd0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("run_pc4", bus.out_pc, 32'd4);

        // Backpressure for three cycles at pc 8
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            chk1("bp_valid", bus.out_valid, 1'b1);
            chk("bp_pc", bus.out_pc, 32'd8);
            chk1("bp_en", bus.imem_en, 1'b0);
        end
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rel_pc8", bus.out_pc, 32'd8);
        chk1("rel_en", bus.imem_en, 1'b1);
        chk("rel_addr", bus.imem_addr, 32'd12);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rel_pc12", bus.out_pc, 32'd12);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rel_pc16", bus.out_pc, 32'd16);
        chk("rel_instr16", bus.out_instr, 32'h80220007);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rel_pc20", bus.out_pc, 32'd20);

        // Redirect with a word in flight
        go(1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
        chk1("rd0_en", bus.imem_en, 1'b0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("rd0_valid", bus.out_valid, 1'b0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rd0_pc", bus.out_pc, 32'd0);
        go(1'b0, 1'b0, 1'b1, 32'd16, 1'b1);
        chk1("rd16_valid", bus.out_valid, 1'b0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rd16_addr", bus.imem_addr, 32'd16);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rd16_pc", bus.out_pc, 32'd16);
        chk("rd16_instr", bus.out_instr, 32'h80220007);

        // Misaligned redirect
        go(1'b0, 1'b0, 1'b1, 32'd18, 1'b1);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("mis_set", mis_o, 1'b1);
        chk("mis_addr", bus.imem_addr, 32'd16);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("mis_pc", bus.out_pc, 32'd16);
        chk1("mis_hold", mis_o, 1'b1);

        // Wrap, then stall
        go(1'b0, 1'b0, 1'b1, 32'd120, 1'b1);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("mis_clr", mis_o, 1'b0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc120", bus.out_pc, 32'd120);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc124", bus.out_pc, 32'd124);
        go(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc0", bus.out_pc, 32'd0);
        chk1("stall1_valid", bus.out_valid, 1'b1);
        go(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk1("stall2_valid", bus.out_valid, 1'b0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("resume_en", bus.imem_en, 1'b1);
        chk("resume_addr", bus.imem_addr, 32'd4);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("resume_pc", bus.out_pc, 32'd4);

        // Reset while the skid holds a word
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("skid_pc8", bus.out_pc, 32'd8);
        go(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk1("skid_full", dut.skid_v_s, 1'b1);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("rstmid_valid", bus.out_valid, 1'b0);
        chk("rstmid_addr", bus.imem_addr, 32'd0);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk1("rstmid_valid2", bus.out_valid, 1'b1);
        chk("rstmid_pc", bus.out_pc, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) < 1);
            st  = ($urandom_range(0, 99) < 20);
            rv  = ($urandom_range(0, 99) < 6);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 140));
            rdy = ($urandom_range(0, 99) < 70);
            go(r, st, rv, rpc, rdy);
        end

        // Steady-state throughput
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        x0 = xfers;
        for (int i = 0; i < 10; i++) go(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("throughput", 32'(xfers - x0), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
